// File: rtl/pac_pkg.sv
// pac_pkg: shared definitions for the Pac-Man movement slice.
//   - Default position width and screen limits, also used by the
//     renderer and the maze ROM.
//   - Direction encoding (RIGHT=0, LEFT=1, UP=2, DOWN=3).
//   - Movement FSM state encoding.
//   - button_dir(): turns the synchronised button levels into a
//     direction, with priority up > down > left > right.
package pac_pkg;

    localparam int PAC_POS_W = 10;
    localparam int PAC_H_MAX = 639;
    localparam int PAC_V_MAX = 479;

    typedef enum logic [1:0] {
        DIR_RIGHT = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_Q_WANT,
        ST_Q_CUR,
        ST_MOVE
    } state_t;

    // Right is the fallback, so the caller only calls this when some
    // button is actually pressed.
    function automatic dir_t button_dir(input logic up, input logic down, input logic left);
        if (up)
            return DIR_UP;
        else if (down)
            return DIR_DOWN;
        else if (left)
            return DIR_LEFT;
        return DIR_RIGHT;
    endfunction

endpackage

// File: rtl/pac_move_ctrl_if.sv
// pac_move_ctrl_if: wall-query handshake between the movement controller
// and the maze wall-lookup responder.
//   wq_req        master -> slave  query in progress
//   wq_h, wq_v    master -> slave  queried coordinate, stable while wq_req=1
//   wq_ack        slave  -> master response valid
//   wq_wall       slave  -> master coordinate is a wall (valid with wq_ack)
interface pac_move_ctrl_if #(
    parameter int POS_W = pac_pkg::PAC_POS_W
);
    logic             wq_req;
    logic [POS_W-1:0] wq_h;
    logic [POS_W-1:0] wq_v;
    logic             wq_ack;
    logic             wq_wall;

    modport master (output wq_req, output wq_h, output wq_v, input wq_ack, input wq_wall);
    modport slave  (input wq_req, input wq_h, input wq_v, output wq_ack, output wq_wall);
endinterface

// File: rtl/pac_next_pos.sv
// pac_next_pos: combinational target calculator.
//   cur_h, cur_v  current position
//   dir           direction to step in
//   tgt_h, tgt_v  position one STEP further, wrapped through the screen
//                 edges; the axis not being moved along passes through.
// The arithmetic runs one bit wider than the position so that h+STEP
// cannot overflow before it is compared against the screen limit.
module pac_next_pos
    import pac_pkg::*;
#(
    parameter int POS_W = PAC_POS_W,
    parameter int STEP  = 2,
    parameter int H_MAX = PAC_H_MAX,
    parameter int V_MAX = PAC_V_MAX
) (
    input  logic [POS_W-1:0] cur_h,
    input  logic [POS_W-1:0] cur_v,
    input  dir_t             dir,
    output logic [POS_W-1:0] tgt_h,
    output logic [POS_W-1:0] tgt_v
);
    localparam int EXT_W = POS_W + 1;
    localparam logic [EXT_W-1:0] STEP_X = EXT_W'(STEP);
    localparam logic [EXT_W-1:0] H_LAST = EXT_W'(H_MAX);
    localparam logic [EXT_W-1:0] V_LAST = EXT_W'(V_MAX);
    localparam logic [EXT_W-1:0] H_SPAN = EXT_W'(H_MAX + 1);
    localparam logic [EXT_W-1:0] V_SPAN = EXT_W'(V_MAX + 1);

    logic [EXT_W-1:0] ext_h, ext_v;
    logic [EXT_W-1:0] fwd_h, fwd_v;
    logic [EXT_W-1:0] back_h, back_v;

    // Forward steps wrap past the last coordinate back to the left/top
    // edge; backward steps that would go negative re-enter at the far edge.
    always_comb begin
        ext_h  = {1'b0, cur_h};
        ext_v  = {1'b0, cur_v};
        fwd_h  = ext_h + STEP_X;
        fwd_v  = ext_v + STEP_X;
        back_h = ext_h - STEP_X;
        back_v = ext_v - STEP_X;
        if (fwd_h > H_LAST)
            fwd_h = fwd_h - H_SPAN;
        if (fwd_v > V_LAST)
            fwd_v = fwd_v - V_SPAN;
        if (ext_h < STEP_X)
            back_h = ext_h + H_SPAN - STEP_X;
        if (ext_v < STEP_X)
            back_v = ext_v + V_SPAN - STEP_X;

        tgt_h = cur_h;
        tgt_v = cur_v;
        case (dir)
            DIR_RIGHT: tgt_h = POS_W'(fwd_h);
            DIR_LEFT:  tgt_h = POS_W'(back_h);
            DIR_UP:    tgt_v = POS_W'(back_v);
            DIR_DOWN:  tgt_v = POS_W'(fwd_v);
        endcase
    end

endmodule

// File: rtl/pac_move_ctrl.sv
// pac_move_ctrl: Pac-Man position sequencer.
//   clk                    system clock
//   clr                    asynchronous active-low reset
//   tick                   one-cycle game-step pulse
//   up/down/left/right     synchronised button levels
//   wq                     wall-query handshake (master side)
//   pac_h, pac_v           current position, read by the renderer
//   pac_dir                current heading (RIGHT=0, LEFT=1, UP=2, DOWN=3)
//   moving                 last committed step succeeded
//   busy                   a step is in progress
//   tick_miss              one-cycle pulse: tick arrived while busy
// Each accepted tick first tries the requested turn (if one is pending),
// then falls back to continuing straight, and finally commits the target
// that the accepted query asked about.
module pac_move_ctrl
    import pac_pkg::*;
#(
    parameter int POS_W  = PAC_POS_W,
    parameter int H_INIT = 300,
    parameter int V_INIT = 200,
    parameter int STEP   = 2,
    parameter int H_MAX  = PAC_H_MAX,
    parameter int V_MAX  = PAC_V_MAX
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tick,
    input  logic             up,
    input  logic             down,
    input  logic             left,
    input  logic             right,
    pac_move_ctrl_if.master  wq,
    output logic [POS_W-1:0] pac_h,
    output logic [POS_W-1:0] pac_v,
    output logic [1:0]       pac_dir,
    output logic             moving,
    output logic             busy,
    output logic             tick_miss
);
    state_t           state;
    dir_t             cur_dir;
    dir_t             want_dir;
    logic             want_v;
    dir_t             sel_dir;
    logic [POS_W-1:0] tgt_h, tgt_v;

    assign pac_dir = cur_dir;

    // Only an IDLE tick with a pending turn asks about the wanted direction;
    // every other query (including the fallback after a blocked turn) is
    // about continuing in the current heading.
    assign sel_dir = (state == ST_IDLE && want_v) ? want_dir : cur_dir;

    pac_next_pos #(
        .POS_W (POS_W),
        .STEP  (STEP),
        .H_MAX (H_MAX),
        .V_MAX (V_MAX)
    ) u_next_pos (
        .cur_h (pac_h),
        .cur_v (pac_v),
        .dir   (sel_dir),
        .tgt_h (tgt_h),
        .tgt_v (tgt_v)
    );

    // Movement FSM plus the want register. wq_h/wq_v double as the latched
    // target: MOVE commits whatever coordinate the responder approved.
    // The button update sits after the FSM case so a press in the same
    // cycle as a turn is consumed keeps want_v set.
    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            pac_h     <= POS_W'(H_INIT);
            pac_v     <= POS_W'(V_INIT);
            cur_dir   <= DIR_RIGHT;
            moving    <= 1'b0;
            want_v    <= 1'b0;
            want_dir  <= DIR_RIGHT;
            tick_miss <= 1'b0;
            wq.wq_req <= 1'b0;
            wq.wq_h   <= '0;
            wq.wq_v   <= '0;
        end else begin
            tick_miss <= tick && busy;

            case (state)
                ST_IDLE: begin
                    if (tick && (want_v || moving)) begin
                        state     <= want_v ? ST_Q_WANT : ST_Q_CUR;
                        busy      <= 1'b1;
                        wq.wq_req <= 1'b1;
                        wq.wq_h   <= tgt_h;
                        wq.wq_v   <= tgt_v;
                    end
                end
                ST_Q_WANT: begin
                    if (wq.wq_ack) begin
                        if (!wq.wq_wall) begin
                            cur_dir   <= want_dir;
                            want_v    <= 1'b0;
                            wq.wq_req <= 1'b0;
                            state     <= ST_MOVE;
                        end else begin
                            wq.wq_h <= tgt_h;
                            wq.wq_v <= tgt_v;
                            state   <= ST_Q_CUR;
                        end
                    end
                end
                ST_Q_CUR: begin
                    if (wq.wq_ack) begin
                        wq.wq_req <= 1'b0;
                        if (!wq.wq_wall) begin
                            state <= ST_MOVE;
                        end else begin
                            moving <= 1'b0;
                            busy   <= 1'b0;
                            state  <= ST_IDLE;
                        end
                    end
                end
                ST_MOVE: begin
                    pac_h  <= wq.wq_h;
                    pac_v  <= wq.wq_v;
                    moving <= 1'b1;
                    busy   <= 1'b0;
                    state  <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (up || down || left || right) begin
                want_v   <= 1'b1;
                want_dir <= button_dir(up, down, left);
            end
        end
    end

endmodule

// File: tb/tb_pac_move_ctrl.sv
// tb_pac_move_ctrl: self-checking bench for pac_move_ctrl.
// A transaction-level model keeps a plan of outstanding wall queries per
// accepted tick and is compared against every DUT output on each falling
// edge; directed sequences pin the model with literal positions.
module tb_pac_move_ctrl;
    import pac_pkg::*;

    localparam int POS_W  = 10;
    localparam int H_INIT = 300;
    localparam int V_INIT = 200;
    localparam int STEP   = 2;
    localparam int H_MAX  = 639;
    localparam int V_MAX  = 479;

    logic             clk   = 1'b0;
    logic             clr   = 1'b0;
    logic             tick  = 1'b0;
    logic             up    = 1'b0;
    logic             down  = 1'b0;
    logic             left  = 1'b0;
    logic             right = 1'b0;
    logic [POS_W-1:0] pac_h, pac_v;
    logic [1:0]       pac_dir;
    logic             moving, busy, tick_miss;

    pac_move_ctrl_if #(.POS_W(POS_W)) wq_bus ();

    pac_move_ctrl #(
        .POS_W (POS_W), .H_INIT (H_INIT), .V_INIT (V_INIT),
        .STEP (STEP), .H_MAX (H_MAX), .V_MAX (V_MAX)
    ) dut (
        .clk (clk), .clr (clr), .tick (tick),
        .up (up), .down (down), .left (left), .right (right),
        .wq (wq_bus),
        .pac_h (pac_h), .pac_v (pac_v), .pac_dir (pac_dir),
        .moving (moving), .busy (busy), .tick_miss (tick_miss)
    );

    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check_output(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int h;
        int v;
        bit turn;
    } query_t;

    query_t plan[$];
    int     m_h = H_INIT, m_v = V_INIT, m_dir = 0, m_want_dir = 0;
    bit     m_moving = 0, m_want_v = 0, m_miss = 0, m_commit = 0;
    int     m_commit_h = 0, m_commit_v = 0, m_wq_h = 0, m_wq_v = 0;
    bit     mt_busy, mt_do_commit;
    query_t mt_q;

    function automatic query_t make_query(input int h, input int v, input int dir, input bit turn);
        query_t q;
        q.h = h;
        q.v = v;
        case (dir)
            0: q.h = (h + STEP) % (H_MAX + 1);
            1: q.h = (h - STEP + H_MAX + 1) % (H_MAX + 1);
            2: q.v = (v - STEP + V_MAX + 1) % (V_MAX + 1);
            default: q.v = (v + STEP) % (V_MAX + 1);
        endcase
        q.turn = turn;
        return q;
    endfunction

    function automatic bit model_busy();
        return (plan.size() != 0) || m_commit;
    endfunction

    always @(posedge clk or negedge clr) begin
        if (!clr) begin
            plan.delete();
            m_h = H_INIT; m_v = V_INIT; m_dir = 0; m_want_dir = 0;
            m_moving = 0; m_want_v = 0; m_miss = 0; m_commit = 0;
            m_wq_h = 0; m_wq_v = 0;
        end else begin
            mt_busy      = model_busy();
            mt_do_commit = m_commit;
            m_commit     = 0;
            m_miss       = tick && mt_busy;
            if (mt_do_commit) begin
                m_h      = m_commit_h;
                m_v      = m_commit_v;
                m_moving = 1;
            end else if (plan.size() != 0) begin
                if (wq_bus.wq_ack) begin
                    mt_q = plan.pop_front();
                    if (!wq_bus.wq_wall) begin
                        plan.delete();
                        m_commit   = 1;
                        m_commit_h = mt_q.h;
                        m_commit_v = mt_q.v;
                        if (mt_q.turn) begin
                            m_dir    = m_want_dir;
                            m_want_v = 0;
                        end
                    end else if (!mt_q.turn) begin
                        m_moving = 0;
                    end
                end
            end else if (tick) begin
                if (m_want_v) begin
                    plan.push_back(make_query(m_h, m_v, m_want_dir, 1'b1));
                    plan.push_back(make_query(m_h, m_v, m_dir, 1'b0));
                end else if (m_moving) begin
                    plan.push_back(make_query(m_h, m_v, m_dir, 1'b0));
                end
            end
            if (plan.size() != 0) begin
                m_wq_h = plan[0].h;
                m_wq_v = plan[0].v;
            end
            if (up || down || left || right) begin
                m_want_v   = 1;
                m_want_dir = up ? 2 : down ? 3 : left ? 1 : 0;
            end
        end
    end

    // Compare every output against the model once per cycle.
    always @(negedge clk) begin
        if (clr) begin
            check_output("pac_h", int'(pac_h), m_h);
            check_output("pac_v", int'(pac_v), m_v);
            check_output("pac_dir", int'(pac_dir), m_dir);
            check_output("moving", int'(moving), int'(m_moving));
            check_output("busy", int'(busy), int'(model_busy()));
            check_output("tick_miss", int'(tick_miss), int'(m_miss));
            check_output("wq_req", int'(wq_bus.wq_req), int'(plan.size() != 0));
            check_output("wq_h", int'(wq_bus.wq_h), m_wq_h);
            check_output("wq_v", int'(wq_bus.wq_v), m_wq_v);
        end
    end

    // ---------------- wall responder ----------------
    int resp_delay    = 0;
    int resp_wait     = 0;
    bit resp_spurious = 0;
    bit resp_random   = 0;
    bit wall_q[$];

    always @(negedge clk) begin
        if (wq_bus.wq_req) begin
            if (wq_bus.wq_ack)
                resp_wait = 0;
            if (resp_wait >= resp_delay) begin
                wq_bus.wq_ack = 1'b1;
                if (wall_q.size() != 0)
                    wq_bus.wq_wall = wall_q.pop_front();
                else
                    wq_bus.wq_wall = resp_random ? ($urandom_range(0, 2) == 0) : 1'b0;
            end else begin
                wq_bus.wq_ack  = 1'b0;
                wq_bus.wq_wall = 1'($urandom_range(0, 1));
                resp_wait++;
            end
        end else begin
            resp_wait      = 0;
            wq_bus.wq_ack  = resp_spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            wq_bus.wq_wall = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- stimulus ----------------
    // btn = {up, down, left, right}
    task automatic apply_stimulus(input bit t, input logic [3:0] btn);
        @(negedge clk);
        tick = t;
        {up, down, left, right} = btn;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_output("idle_timeout", int'(busy), 0);
    endtask

    task automatic run_tick();
        apply_stimulus(1'b1, 4'b0000);
        apply_stimulus(1'b0, 4'b0000);
        wait_idle();
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int h0, v0, misses;
        logic [3:0] btn;

        // Reset values
        repeat (3) @(negedge clk);
        check_output("rst_pac_h", int'(pac_h), 300);
        check_output("rst_pac_v", int'(pac_v), 200);
        check_output("rst_dir", int'(pac_dir), 0);
        check_output("rst_moving", int'(moving), 0);
        check_output("rst_busy", int'(busy), 0);
        check_output("rst_wq_req", int'(wq_bus.wq_req), 0);
        check_output("rst_wq_h", int'(wq_bus.wq_h), 0);
        clr = 1'b1;

        // First move right with a same-cycle ack
        apply_stimulus(1'b0, 4'b0001);
        apply_stimulus(1'b1, 4'b0000);
        apply_stimulus(1'b0, 4'b0000);
        check_output("t1_wq_req", int'(wq_bus.wq_req), 1);
        check_output("t1_wq_h", int'(wq_bus.wq_h), 302);
        check_output("t1_wq_v", int'(wq_bus.wq_v), 200);
        @(negedge clk);
        check_output("t1_pac_h_early", int'(pac_h), 300);
        @(negedge clk);
        check_output("t1_pac_h", int'(pac_h), 302);
        check_output("t1_moving", int'(moving), 1);

        // Blocked turn up, continue right, then retry succeeds
        wall_q = '{1'b1, 1'b0};
        apply_stimulus(1'b0, 4'b1000);
        apply_stimulus(1'b1, 4'b0000);
        apply_stimulus(1'b0, 4'b0000);
        check_output("t2_turn_wq_v", int'(wq_bus.wq_v), 198);
        @(negedge clk);
        check_output("t2_cur_wq_req", int'(wq_bus.wq_req), 1);
        check_output("t2_cur_wq_h", int'(wq_bus.wq_h), 304);
        check_output("t2_cur_wq_v", int'(wq_bus.wq_v), 200);
        wait_idle();
        check_output("t2_pac_h", int'(pac_h), 304);
        check_output("t2_dir", int'(pac_dir), 0);
        run_tick();
        check_output("t2_retry_pac_v", int'(pac_v), 198);
        check_output("t2_retry_dir", int'(pac_dir), 2);

        // Horizontal wrap both ways
        apply_stimulus(1'b0, 4'b0001);
        for (int i = 0; i < 167; i++) run_tick();
        check_output("t3_pac_h_638", int'(pac_h), 638);
        run_tick();
        check_output("t3_wrap_right", int'(pac_h), 0);
        apply_stimulus(1'b0, 4'b0010);
        run_tick();
        check_output("t3_wrap_left", int'(pac_h), 638);
        check_output("t3_dir_left", int'(pac_dir), 1);
        run_tick();
        check_output("t3_pac_h_636", int'(pac_h), 636);

        // Vertical wrap both ways
        apply_stimulus(1'b0, 4'b1000);
        for (int i = 0; i < 99; i++) run_tick();
        check_output("t3_pac_v_0", int'(pac_v), 0);
        run_tick();
        check_output("t3_wrap_up", int'(pac_v), 478);
        apply_stimulus(1'b0, 4'b0100);
        run_tick();
        check_output("t3_wrap_down", int'(pac_v), 0);
        check_output("t3_dir_down", int'(pac_dir), 3);

        // Wall ahead while heading down: stop, then stay idle
        wall_q = '{1'b1};
        run_tick();
        check_output("t4_moving", int'(moving), 0);
        check_output("t4_pac_v", int'(pac_v), 0);
        check_output("t4_pac_h", int'(pac_h), 636);
        for (int i = 0; i < 3; i++) begin
            apply_stimulus(1'b1, 4'b0000);
            apply_stimulus(1'b0, 4'b0000);
            check_output("t4_idle_busy", int'(busy), 0);
            check_output("t4_idle_wq_req", int'(wq_bus.wq_req), 0);
        end

        // Stalled responder with a tick during the stall
        resp_delay = 10;
        apply_stimulus(1'b0, 4'b0001);
        apply_stimulus(1'b1, 4'b0000);
        apply_stimulus(1'b0, 4'b0000);
        h0 = int'(wq_bus.wq_h);
        v0 = int'(wq_bus.wq_v);
        check_output("t5_wq_h", h0, 638);
        check_output("t5_wq_v", v0, 0);
        misses = 0;
        for (int i = 0; i < 14; i++) begin
            apply_stimulus(i == 3, 4'b0000);
            if (tick_miss) misses++;
            if (wq_bus.wq_req) begin
                check_output("t5_stable_h", int'(wq_bus.wq_h), h0);
                check_output("t5_stable_v", int'(wq_bus.wq_v), v0);
            end
        end
        wait_idle();
        check_output("t5_miss_count", misses, 1);
        check_output("t5_pac_h", int'(pac_h), 638);
        check_output("t5_moving", int'(moving), 1);

        // Reset in the middle of a query, then a late ack
        resp_delay = 100;
        apply_stimulus(1'b1, 4'b0000);
        apply_stimulus(1'b0, 4'b0000);
        check_output("t6_wq_req_before", int'(wq_bus.wq_req), 1);
        #2 clr = 1'b0;
        #1;
        check_output("t6_wq_req", int'(wq_bus.wq_req), 0);
        check_output("t6_pac_h", int'(pac_h), 300);
        check_output("t6_pac_v", int'(pac_v), 200);
        check_output("t6_dir", int'(pac_dir), 0);
        check_output("t6_busy", int'(busy), 0);
        wall_q.delete();
        resp_delay = 0;
        @(negedge clk);
        clr = 1'b1;
        resp_spurious = 1'b1;
        repeat (5) @(negedge clk);
        check_output("t6_late_ack_req", int'(wq_bus.wq_req), 0);
        check_output("t6_late_ack_h", int'(pac_h), 300);

        // Randomised play against the model
        resp_random = 1'b1;
        apply_stimulus(1'b0, 4'b0001);
        for (int i = 0; i < 3000; i++) begin
            bit t;
            t   = ($urandom_range(0, 3) == 0);
            btn = 4'b0000;
            if (!busy && !t && $urandom_range(0, 5) == 0)
                btn = ($urandom_range(0, 1) == 0) ? 4'(1 << $urandom_range(0, 3))
                                                  : 4'($urandom_range(1, 15));
            if (!wq_bus.wq_req)
                resp_delay = $urandom_range(0, 3);
            apply_stimulus(t, btn);
        end
        apply_stimulus(1'b0, 4'b0000);
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pac_move_ctrl.md
# pac_move_ctrl

Sequences Pac-Man's position register for the game logic. Latches joystick direction requests and, on each game-tick pulse, checks the next position with the maze wall-lookup responder over a req/ack handshake. It either turns (buffered cornering), continues, or stops against a wall, then commits the new position with screen wrap-around. It sits between the button synchronisers, the maze ROM arbiter and the renderer, which reads `pac_h`/`pac_v`.

## Interface
- `POS_W`, 10: position width in bits.
- `H_INIT`, 300: horizontal reset position.
- `V_INIT`, 200: vertical reset position.
- `STEP`, 2: pixels moved per tick; must be ≥1 and ≤ `H_MAX`, `V_MAX`.
- `H_MAX`, 639: last valid horizontal coordinate.
- `V_MAX`, 479: last valid vertical coordinate.
- `clk`  in  1  system clock.
- `clr`  in  1  asynchronous, active-low reset.
- `tick`  in  1  one-cycle game-step pulse.
- `up`, `down`, `left`, `right`  in  1 each  synchronised button levels.
- `wq_req`  out  1  wall query request.
- `wq_h`, `wq_v`  out  `POS_W` each  queried coordinate.
- `wq_ack`  in  1  query response valid.
- `wq_wall`  in  1  queried coordinate is a wall; valid only with `wq_ack`.
- `pac_h`, `pac_v`  out  `POS_W` each  current position.
- `pac_dir`  out  2  current heading.
- `moving`  out  1  last committed step succeeded.
- `busy`  out  1  FSM not in IDLE.
- `tick_miss`  out  1  one-cycle pulse: `tick` arrived while busy.

## Operation
- Direction encoding: RIGHT=0, LEFT=1, UP=2, DOWN=3.
- Want register: any cycle a button is high, `want_dir` ← highest-priority pressed button (up > down > left > right) and `want_v` ← 1. Priority applies to simultaneous presses. A press in the same cycle the FSM clears `want_v` wins, leaving `want_v`=1.
- FSM states: IDLE, Q_WANT, Q_CUR, MOVE.
  - IDLE + `tick`: go to Q_WANT if `want_v`; else to Q_CUR if `moving`; else stay in IDLE.
  - Q_WANT: query target(`want_dir`). On `wq_ack`:
    - `!wq_wall`: `pac_dir` ← `want_dir`, `want_v` ← 0, go to MOVE.
    - Wall: go to Q_CUR. `want_v` is kept, so the turn is retried next tick.
  - Q_CUR: query target(`pac_dir`). On `wq_ack`:
    - `!wq_wall`: go to MOVE.
    - Wall: `moving` ← 0, go to IDLE.
  - MOVE: `pac_h`/`pac_v` ← latched target, `moving` ← 1, go to IDLE.
- Target arithmetic is done in `POS_W+1` bits, with wrap-around (tunnel):
  - RIGHT: `h+STEP > H_MAX` gives `h+STEP-(H_MAX+1)`.
  - LEFT: `h < STEP` gives `h+(H_MAX+1)-STEP`.
  - DOWN and UP: same rules on v with `V_MAX`.
  - The non-moving axis is unchanged.
- Handshake:
  - `wq_req` is asserted throughout Q_WANT/Q_CUR.
  - `wq_h`/`wq_v` are registered on state entry and held stable while `wq_req`=1.
  - `wq_ack` is sampled only while `wq_req`=1. `wq_ack` outside a query is ignored.
  - The responder may stall indefinitely; there is no timeout.
- `tick` while `busy`: dropped, and `tick_miss` pulses next cycle.
- Reset (asynchronous, mid-query included):
  - Position outputs: `pac_h`=`H_INIT`, `pac_v`=`V_INIT`, `pac_dir`=RIGHT.
  - Flags: `moving`=0, `want_v`=0, `tick_miss`=0.
  - Query outputs: `wq_req`=0, `wq_h`=0, `wq_v`=0.
  - FSM returns to IDLE, so `busy`=0.
  - An interrupted query is abandoned; the responder must tolerate the `wq_req` drop.

## Timing
- `tick` at edge n: the query state is entered and `wq_req`=1 from cycle n+1.
- Ack sampled at edge m: MOVE (or Q_CUR/IDLE) from cycle m+1. Position is visible from cycle m+2.
- Minimum tick-to-position latency is 3 cycles with a same-cycle ack. A failed turn plus a successful continue takes a minimum of 4 cycles.
- `wq_req` deasserts in the cycle after the accepting ack, except on a Q_WANT→Q_CUR transition, where it stays high with a new address.
- All outputs are registered.

## Structure
- `pac_pkg` holds:
  - the direction enum/localparams;
  - FSM state encoding;
  - `POS_W`, `H_MAX`, `V_MAX` defaults, shared with the renderer and maze ROM.
- One natural sub-module is `pac_next_pos`: a combinational target calculator (position, direction, `STEP` → wrapped target). It is instantiated once and muxed by state.

## Test plan
- Reset with defaults, then `right`, then `tick` with `wq_ack` on the first `wq_req` cycle and `wq_wall`=0: `wq_h`=302, `wq_v`=200, `pac_h`=302 three cycles after `tick`, `moving`=1.
- At (300,200) heading RIGHT and moving, press `up`, and the UP query returns wall: Q_CUR queries (302,200), `pac_h`=302, `pac_dir` stays RIGHT, `want_v` is still 1. On the next tick UP is free, so `pac_v`=198 and `pac_dir`=UP.
- At (638,100) heading RIGHT, tick with no wall: `pac_h`=0. At (1,100) heading LEFT: `pac_h`=639.
- Heading DOWN with a wall ahead: `moving`=0, position unchanged. Further ticks with no buttons pressed keep `busy`=0 and issue no `wq_req`.
- Hold `wq_ack` low for 10 cycles and pulse `tick` during the stall: `wq_h`/`wq_v` are stable, `tick_miss` pulses once, and the ack then completes normally.
- Assert `clr` low while `wq_req`=1: `wq_req`=0 immediately, position returns to (300,200), `pac_dir`=RIGHT. A late `wq_ack` after release is ignored.
